// File: rtl/magia_fsync_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : magia_fsync_ctrl
// Desc     : Tile-side Fractal Sync barrier controller (request/ack/wake).
//            Define MAGIA_FSYNC_TIMEOUT_EN to enable the wake-wait timeout.
// Revision : 1.0
// ----------------------------------------------------------------------------
module magia_fsync_ctrl #(
  parameter int N_LVL     = 2,
  parameter int LVL_W     = N_LVL + 1,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [LVL_W-1:0]     req_aggr_i,
  input  logic [TIMEOUT_W-1:0] timeout_cycles_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic                 irq_o,
  input  logic                 irq_clr_i,
  output logic                 fsync_req_o,
  output logic [LVL_W-1:0]     fsync_aggr_o,
  input  logic                 fsync_ack_i,
  input  logic                 fsync_wake_i
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [LVL_W-1:0] aggr_q, aggr_d;
  logic             irq_q, irq_d;
  logic             timeout_hit;

`ifdef MAGIA_FSYNC_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] cnt_q, cnt_d;

  // Counter is zero outside WAIT, so it always starts from zero on entry.
  always_comb begin
    cnt_d = '0;
    if (state_q == S_WAIT && state_d == S_WAIT) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout_hit = (timeout_cycles_i != '0) &&
                       (cnt_q == timeout_cycles_i - 1'b1);
`else
  logic unused_timeout;
  assign unused_timeout = ^timeout_cycles_i;
  assign timeout_hit    = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    aggr_d  = aggr_q;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          if (req_aggr_i == '0) begin
            state_d = S_ERR;
          end else begin
            aggr_d  = req_aggr_i;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (fsync_ack_i) begin
          state_d = fsync_wake_i ? S_DONE : S_WAIT;
        end
      end
      S_WAIT: begin
        // Wake wins over a timeout expiring in the same cycle.
        if (fsync_wake_i) begin
          state_d = S_DONE;
        end else if (timeout_hit) begin
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Set from DONE overrides a coincident clear.
  always_comb begin
    irq_d = (state_q == S_DONE) | (irq_q & ~irq_clr_i);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      aggr_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      aggr_q  <= aggr_d;
      irq_q   <= irq_d;
    end
  end

  assign req_ready_o  = (state_q == S_IDLE);
  assign busy_o       = (state_q != S_IDLE);
  assign fsync_req_o  = (state_q == S_REQ);
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);
  assign irq_o        = irq_q | (state_q == S_DONE);
  assign fsync_aggr_o = aggr_q;

endmodule
`default_nettype wire

// File: tb/tb_magia_fsync_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_magia_fsync_ctrl
// Desc     : Self-checking bench for magia_fsync_ctrl using an event-timeline
//            model; honours MAGIA_FSYNC_TIMEOUT_EN when defined.
// Revision : 1.0
// ----------------------------------------------------------------------------
module tb_magia_fsync_ctrl;
  localparam int LVL_W     = 3;
  localparam int TIMEOUT_W = 16;
  localparam int MAXC      = 64;
`ifdef MAGIA_FSYNC_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                 clk_i;
  logic                 rst_i;
  logic                 req_valid_i;
  logic                 req_ready_o;
  logic [LVL_W-1:0]     req_aggr_i;
  logic [TIMEOUT_W-1:0] timeout_cycles_i;
  logic                 busy_o;
  logic                 done_o;
  logic                 err_o;
  logic                 irq_o;
  logic                 irq_clr_i;
  logic                 fsync_req_o;
  logic [LVL_W-1:0]     fsync_aggr_o;
  logic                 fsync_ack_i;
  logic                 fsync_wake_i;

  magia_fsync_ctrl #(.N_LVL(2), .LVL_W(LVL_W), .TIMEOUT_W(TIMEOUT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_aggr_i(req_aggr_i),
    .timeout_cycles_i(timeout_cycles_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .irq_o(irq_o), .irq_clr_i(irq_clr_i),
    .fsync_req_o(fsync_req_o), .fsync_aggr_o(fsync_aggr_o),
    .fsync_ack_i(fsync_ack_i), .fsync_wake_i(fsync_wake_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Output vector layout: {ready, busy, fsync_req, done, err, irq}
  logic [5:0]       exp_v    [0:MAXC];
  logic [5:0]       obs_v    [0:MAXC];
  logic [LVL_W-1:0] obs_aggr [0:MAXC];
  bit               clr_pat  [0:MAXC];
  int               run_len;
  int               model_f;
  bit               model_ok;
  bit               irq_carry;
  logic [LVL_W-1:0] cur_mask;
  int               cur_a, cur_w, cur_sp, cur_t;

  // Timeline model: cycle 0 = accept, ack at a, wake at w, spurious wake at sp.
  task automatic build_model(input logic [LVL_W-1:0] mask, input int a, input int w,
                             input int sp, input int t, input int extra);
    int e;
    cur_mask = mask; cur_a = a; cur_w = w; cur_sp = sp; cur_t = t;
    if (mask == '0) begin
      model_f = 1; model_ok = 1'b0;
    end else if (w == a) begin
      model_f = a + 1; model_ok = 1'b1;
    end else begin
      e = a + 1;
      if (TO_EN && t != 0 && (w < 0 || w >= e + t)) begin
        model_f = e + t; model_ok = 1'b0;
      end else begin
        model_f = w + 1; model_ok = 1'b1;
      end
    end
    run_len = model_f + 2 + extra;
    if (w + 2 > run_len) run_len = w + 2;
    for (int k = 0; k <= run_len; k++) begin
      int ld;
      bit has, irq, rdy, bsy, rq, dn, er;
      has = 1'b0; ld = -1;
      if (model_ok && model_f <= k) begin has = 1'b1; ld = model_f; end
      else if (irq_carry)           begin has = 1'b1; ld = -1; end
      irq = has;
      for (int c = ld + 1; c < k; c++) if (clr_pat[c]) irq = 1'b0;
      rdy = (k == 0) || (k > model_f);
      bsy = (k >= 1) && (k <= model_f);
      rq  = (mask != '0) && (k >= 1) && (k <= a);
      dn  = model_ok && (k == model_f);
      er  = !model_ok && (k == model_f);
      exp_v[k] = {rdy, bsy, rq, dn, er, irq};
    end
    irq_carry = exp_v[run_len][0];
  endtask

  task automatic set_clr(input int pct);
    for (int k = 0; k <= MAXC; k++) clr_pat[k] = ($urandom_range(0, 99) < pct);
  endtask

  task automatic idle_inputs();
    req_valid_i = 1'b0; req_aggr_i = '0; fsync_ack_i = 1'b0;
    fsync_wake_i = 1'b0; irq_clr_i = 1'b0;
  endtask

  // Drives the modelled barrier and records outputs mid-cycle.
  task automatic run_barrier();
    for (int k = 0; k < run_len; k++) begin
      @(posedge clk_i); #1;
      idle_inputs();
      if (k == 0) begin
        req_valid_i = 1'b1; req_aggr_i = cur_mask;
      end else if (k <= model_f) begin
        req_valid_i = 1'($urandom_range(0, 1));
        req_aggr_i  = LVL_W'($urandom_range(1, 7));
      end
      if (cur_mask != '0 && k == cur_a) fsync_ack_i = 1'b1;
      if (k == cur_w || k == cur_sp)   fsync_wake_i = 1'b1;
      irq_clr_i        = clr_pat[k];
      timeout_cycles_i = TIMEOUT_W'(cur_t);
      @(negedge clk_i);
      obs_v[k]    = {req_ready_o, busy_o, fsync_req_o, done_o, err_o, irq_o};
      obs_aggr[k] = fsync_aggr_o;
    end
    @(posedge clk_i); #1;
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs(); timeout_cycles_i = '0; rst_i = 1'b1;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, busy_o, fsync_req_o, done_o, err_o, irq_o} !== 6'b100000 || fsync_aggr_o !== '0) begin
      failures++;
      $display("FAIL reset_hold got=%b aggr=%b exp=100000 aggr=000",
               {req_ready_o, busy_o, fsync_req_o, done_o, err_o, irq_o}, fsync_aggr_o);
    end
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(negedge clk_i);
    checks++;
    if ({req_ready_o, busy_o, fsync_req_o, done_o, err_o, irq_o} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_release got=%b exp=100000",
               {req_ready_o, busy_o, fsync_req_o, done_o, err_o, irq_o});
    end
    irq_carry = 1'b0;
  endtask

  task automatic test_basic();
    for (int k = 0; k <= MAXC; k++) clr_pat[k] = 1'b0;
    clr_pat[10] = 1'b1;
    build_model(3'b011, 2, 7, -1, 0, 3);
    run_barrier();
    for (int k = 0; k < run_len; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        failures++;
        $display("FAIL basic cyc=%0d rdy/busy/req/done/err/irq got=%b exp=%b", k, obs_v[k], exp_v[k]);
      end
      if (exp_v[k][3]) begin
        checks++;
        if (obs_aggr[k] !== cur_mask) begin
          failures++;
          $display("FAIL basic_aggr cyc=%0d got=%b exp=%b", k, obs_aggr[k], cur_mask);
        end
      end
    end
  endtask

  task automatic test_same_cycle();
    int a;
    for (int i = 0; i < 3; i++) begin
      a = (i == 0) ? 1 : int'($urandom_range(1, 4));
      set_clr(0);
      build_model(LVL_W'($urandom_range(1, 7)), a, a, -1, int'($urandom_range(0, 5)), 0);
      run_barrier();
      for (int k = 0; k < run_len; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          failures++;
          $display("FAIL same_cycle cyc=%0d rdy/busy/req/done/err/irq got=%b exp=%b", k, obs_v[k], exp_v[k]);
        end
      end
    end
  endtask

  task automatic test_zero_mask();
    set_clr(0);
    build_model('0, 1, -1, 1, 0, 2);
    run_barrier();
    for (int k = 0; k < run_len; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        failures++;
        $display("FAIL zero_mask cyc=%0d rdy/busy/req/done/err/irq got=%b exp=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_timeout();
    // Late wake (after expiry) then a normal request with the same timeout.
    set_clr(0);
    build_model(3'b100, 1, 7, -1, 4, 0);
    run_barrier();
    for (int k = 0; k < run_len; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        failures++;
        $display("FAIL timeout cyc=%0d rdy/busy/req/done/err/irq got=%b exp=%b", k, obs_v[k], exp_v[k]);
      end
    end
    build_model(3'b110, 2, 4, -1, 4, 0);
    run_barrier();
    for (int k = 0; k < run_len; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        failures++;
        $display("FAIL timeout_next cyc=%0d rdy/busy/req/done/err/irq got=%b exp=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_wake_timeout_tie();
    set_clr(0);
    build_model(3'b001, 2, 5, -1, 3, 0);
    run_barrier();
    for (int k = 0; k < run_len; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        failures++;
        $display("FAIL tie cyc=%0d rdy/busy/req/done/err/irq got=%b exp=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int a, w, sp;
    for (int i = 0; i < 16; i++) begin
      a  = int'($urandom_range(1, 5));
      w  = ($urandom_range(0, 3) == 0) ? a : a + 1 + int'($urandom_range(0, 10));
      sp = (a > 1 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, a - 1)) : -1;
      set_clr(25);
      build_model(LVL_W'($urandom_range(0, 7)), a, w, sp, int'($urandom_range(0, 8)),
                  int'($urandom_range(0, 2)));
      run_barrier();
      for (int k = 0; k < run_len; k++) begin
        checks++;
        if (obs_v[k] !== exp_v[k]) begin
          failures++;
          $display("FAIL b2b it=%0d cyc=%0d rdy/busy/req/done/err/irq got=%b exp=%b", i, k, obs_v[k], exp_v[k]);
        end
        if (exp_v[k][3]) begin
          checks++;
          if (obs_aggr[k] !== cur_mask) begin
            failures++;
            $display("FAIL b2b_aggr it=%0d cyc=%0d got=%b exp=%b", i, k, obs_aggr[k], cur_mask);
          end
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    // Leave irq set so the reset has something to clear.
    set_clr(0);
    build_model(3'b010, 1, 2, -1, 0, 0);
    run_barrier();
    @(posedge clk_i); #1; req_valid_i = 1'b1; req_aggr_i = 3'b101;
    @(posedge clk_i); #1; req_valid_i = 1'b0; fsync_ack_i = 1'b1;
    @(posedge clk_i); #1; fsync_ack_i = 1'b0;
    checks++;
    if ({busy_o, fsync_req_o, irq_o} !== 3'b101) begin
      failures++;
      $display("FAIL pre_reset_wait busy/req/irq got=%b exp=101", {busy_o, fsync_req_o, irq_o});
    end
    #2; rst_i = 1'b1; #1;
    checks++;
    if ({req_ready_o, busy_o, fsync_req_o, done_o, err_o, irq_o} !== 6'b100000 || fsync_aggr_o !== '0) begin
      failures++;
      $display("FAIL reset_in_wait got=%b aggr=%b exp=100000 aggr=000",
               {req_ready_o, busy_o, fsync_req_o, done_o, err_o, irq_o}, fsync_aggr_o);
    end
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(posedge clk_i); #1; req_valid_i = 1'b1; req_aggr_i = 3'b010;
    @(posedge clk_i); #1; req_valid_i = 1'b0; #2;
    checks++;
    if (fsync_req_o !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset_req got=%b exp=1", fsync_req_o);
    end
    rst_i = 1'b1; #1;
    checks++;
    if ({fsync_req_o, busy_o, req_ready_o} !== 3'b001) begin
      failures++;
      $display("FAIL reset_in_req req/busy/ready got=%b exp=001", {fsync_req_o, busy_o, req_ready_o});
    end
    @(posedge clk_i); #1; rst_i = 1'b0;
    @(negedge clk_i);
    irq_carry = 1'b0;
    set_clr(0);
    build_model(3'b111, 2, 6, -1, 0, 1);
    run_barrier();
    for (int k = 0; k < run_len; k++) begin
      checks++;
      if (obs_v[k] !== exp_v[k]) begin
        failures++;
        $display("FAIL after_reset cyc=%0d rdy/busy/req/done/err/irq got=%b exp=%b", k, obs_v[k], exp_v[k]);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    idle_inputs();
    timeout_cycles_i = '0;
    irq_carry = 1'b0;
    test_reset();
    test_basic();
    test_same_cycle();
    test_zero_mask();
    test_timeout();
    test_wake_timeout_tie();
    test_back_to_back();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
